// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package seq_det_pkg;

    localparam logic [5:0] DEFAULT_PATTERN_6 = 6'b110011;

    // Bits needed to count 0..w inclusive.
    function automatic int seq_det_fill_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter: clr wins over inc, holds at all-ones once reached.
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/detect_sequence_programmable.sv
// Serial pattern detector with runtime pattern/mask, overlap control and match counter.
// Optional last-match index output enabled by defining SEQ_DET_LAST_IDX_EN.
module detect_sequence_programmable
    import seq_det_pkg::*;
#(
    parameter int             W           = 6,
    parameter int             CNT_W       = 8,
    parameter logic [W-1:0]   RST_PATTERN = DEFAULT_PATTERN_6,
    parameter logic [W-1:0]   RST_MASK    = '1,
    parameter logic           RST_OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             new_bit,
    input  logic             cfg_load,
    input  logic [W-1:0]     cfg_pattern,
    input  logic [W-1:0]     cfg_mask,
    input  logic             cfg_overlap,
`ifdef SEQ_DET_LAST_IDX_EN
    output logic [15:0]      last_idx,
`endif
    output logic             detected,
    output logic [CNT_W-1:0] match_count
);

    localparam int FILL_W = seq_det_fill_w(W);

    logic [W-1:0]      r_history;
    logic [W-1:0]      r_pattern;
    logic [W-1:0]      r_mask;
    logic              r_overlap;
    logic [FILL_W-1:0] r_fill;
    logic              r_detected;

    logic [W-1:0]      w_history_next;
    logic [FILL_W-1:0] w_fill_next;
    logic [W-1:0]      w_bit_miss;
    logic              w_full;
    logic              w_accept;
    logic              w_hit;

    assign w_accept       = in_valid && !cfg_load;
    assign w_history_next = {r_history[W-2:0], new_bit};
    assign w_fill_next    = (r_fill == FILL_W'(W)) ? r_fill : r_fill + 1'b1;
    assign w_full         = (w_fill_next == FILL_W'(W));

    // Per-bit mismatch, suppressed where the mask marks a don't-care.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cmp
            assign w_bit_miss[gi] = r_mask[gi] & (w_history_next[gi] ^ r_pattern[gi]);
        end
    endgenerate

    assign w_hit = w_accept && w_full && (w_bit_miss == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pattern <= RST_PATTERN;
            r_mask    <= RST_MASK;
            r_overlap <= RST_OVERLAP;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_mask    <= cfg_mask;
            r_overlap <= cfg_overlap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_history  <= '0;
            r_fill     <= '0;
            r_detected <= 1'b0;
        end else if (cfg_load) begin
            r_history  <= '0;
            r_fill     <= '0;
            r_detected <= 1'b0;
        end else if (in_valid) begin
            r_history  <= w_history_next;
            // Non-overlap mode demands W fresh bits before the next match.
            r_fill     <= (w_hit && !r_overlap) ? '0 : w_fill_next;
            r_detected <= w_hit;
        end else begin
            r_detected <= 1'b0;
        end
    end

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit),
        .clr   (cfg_load),
        .count (match_count)
    );

    assign detected = r_detected;

`ifdef SEQ_DET_LAST_IDX_EN
    logic [15:0] r_bit_idx;
    logic [15:0] r_last_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_idx  <= '0;
            r_last_idx <= '0;
        end else if (cfg_load) begin
            r_bit_idx  <= '0;
            r_last_idx <= '0;
        end else if (in_valid) begin
            r_bit_idx <= r_bit_idx + 16'd1;
            if (w_hit) begin
                r_last_idx <= r_bit_idx;
            end
        end
    end

    assign last_idx = r_last_idx;
`endif

endmodule
